adler32_arbiter: RTL and testbench

ADLER32_ARBITER -- requirements
Module: adler32_arbiter

---
 rtl/adler32_arbiter_pkg.sv | 19 +
 rtl/adler32_rr_arb.sv | 18 +
 rtl/adler32_arbiter.sv | 146 ++++++++++++++
 tb/tb_adler32_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adler32_arbiter_pkg.sv
// Shared types/constants for the Adler-32 arbiter.
// Holds FSM state enum, widths and empty checksum.
package adler32_arbiter_pkg;

  localparam int SIZE_W = 22;
  localparam int CSUM_W = 32;

  localparam logic [CSUM_W-1:0] ADLER_EMPTY =
    32'h0000_0001;

  typedef enum logic [2:0] {
    IDLE,
    SIZE,
    STREAM,
    WAIT,
    DONE
  } state_e;

endpackage

// File: rtl/adler32_rr_arb.sv
// Two-way round-robin pick: req_i, prio_i -> win_o.
// prio_i names the favoured requester; win_o one-hot.
module adler32_rr_arb (
  input  logic [1:0] req_i,
  input  logic       prio_i,
  output logic [1:0] win_o
);

  always_comb begin
    win_o = 2'b00;
    if (req_i[prio_i]) begin
      win_o[prio_i] = 1'b1;
    end else if (req_i[!prio_i]) begin
      win_o[!prio_i] = 1'b1;
    end
  end

endmodule

// File: rtl/adler32_arbiter.sv
// Arbitrates two requesters onto one Adler-32 engine.
// Ports: req/size/data in, grant/done/result/err out, eng_* link.
module adler32_arbiter
  import adler32_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [SIZE_W-1:0] size0,
  input  logic [SIZE_W-1:0] size1,
  input  logic [7:0]        data0,
  input  logic [7:0]        data1,
  output logic [1:0]        grant,
  output logic [1:0]        done,
  output logic [CSUM_W-1:0] result,
  output logic              err,
  output logic              busy,
  output logic [SIZE_W-1:0] eng_size,
  output logic              eng_size_valid,
  output logic              eng_data_start,
  output logic [7:0]        eng_data,
  input  logic              eng_checksum_valid,
  input  logic [CSUM_W-1:0] eng_checksum
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [SIZE_W-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              win_q, win_d;
  logic              prio_q, prio_d;
  logic [CSUM_W-1:0] result_q, result_d;
  logic              err_q, err_d;

  logic [1:0]        arb_win;
  logic [SIZE_W-1:0] sel_size;

  adler32_rr_arb u_arb (
    .req_i  (req),
    .prio_i (prio_q),
    .win_o  (arb_win)
  );

  assign sel_size = arb_win[1] ? size1 : size0;

  always_comb begin
    state_d        = state_q;
    size_d         = size_q;
    cnt_d          = cnt_q;
    wd_d           = wd_q;
    win_d          = win_q;
    prio_d         = prio_q;
    result_d       = result_q;
    err_d          = err_q;
    grant          = 2'b00;
    done           = 2'b00;
    eng_size_valid = 1'b0;
    eng_data_start = 1'b0;
    eng_data       = 8'h00;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          win_d  = arb_win[1];
          size_d = sel_size;
          if (sel_size == '0) begin
            result_d = ADLER_EMPTY;
            err_d    = 1'b0;
            state_d  = DONE;
          end else begin
            cnt_d   = sel_size;
            state_d = SIZE;
          end
        end
      end
      SIZE: begin
        eng_size_valid = 1'b1;
        grant[win_q]   = 1'b1;
        state_d        = STREAM;
      end
      STREAM: begin
        eng_data       = win_q ? data1 : data0;
        // counter still equals size only on the first byte
        eng_data_start = (cnt_q == size_q);
        cnt_d          = cnt_q - SIZE_W'(1);
        if (cnt_q == SIZE_W'(1)) begin
          wd_d    = WD_W'(1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        // valid wins even on the expiry cycle
        if (eng_checksum_valid) begin
          result_d = eng_checksum;
          err_d    = 1'b0;
          state_d  = DONE;
        end else if (wd_q == WD_W'(TIMEOUT)) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      DONE: begin
        done[win_q] = 1'b1;
        // favour the requester not just served
        prio_d      = !win_q;
        wd_d        = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      size_q   <= '0;
      cnt_q    <= '0;
      wd_q     <= '0;
      win_q    <= 1'b0;
      prio_q   <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      cnt_q    <= cnt_d;
      wd_q     <= wd_d;
      win_q    <= win_d;
      prio_q   <= prio_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign result   = result_q;
  assign err      = err_q;
  assign eng_size = size_q;

endmodule

// File: tb/tb_adler32_arbiter.sv
// Randomised self-checking bench for adler32_arbiter.
// Transfer-timeline model with per-cycle compare.
module tb_adler32_arbiter;
  import adler32_arbiter_pkg::*;

  localparam int TO = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req;
  logic [SIZE_W-1:0] size0, size1;
  logic [7:0]        data0, data1;
  logic [1:0]        grant, done;
  logic [CSUM_W-1:0] result;
  logic              err, busy;
  logic [SIZE_W-1:0] eng_size;
  logic              eng_size_valid;
  logic              eng_data_start;
  logic [7:0]        eng_data;
  logic              eng_checksum_valid;
  logic [CSUM_W-1:0] eng_checksum;

  always #5 clk = ~clk;

  adler32_arbiter #(.TIMEOUT(TO)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req                (req),
    .size0              (size0),
    .size1              (size1),
    .data0              (data0),
    .data1              (data1),
    .grant              (grant),
    .done               (done),
    .result             (result),
    .err                (err),
    .busy               (busy),
    .eng_size           (eng_size),
    .eng_size_valid     (eng_size_valid),
    .eng_data_start     (eng_data_start),
    .eng_data           (eng_data),
    .eng_checksum_valid (eng_checksum_valid),
    .eng_checksum       (eng_checksum)
  );

  int passed = 0;
  int total  = 0;

  function automatic void chk(string nm,
                              logic [31:0] act,
                              logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t",
                  nm, act, exp, $time);
  endfunction

  // expected outputs for the current cycle
  logic [1:0]  e_grant, e_done;
  logic        e_busy, e_esv, e_start, e_err;
  logic [21:0] e_size;
  logic [7:0]  e_data;
  logic [31:0] e_result;
  bit          c_size, c_data, c_err;
  bit          chk_en = 1'b0;

  // model state
  int          prio_m;
  logic [31:0] res_m;
  logic [7:0]  bytes_m [0:15];

  logic [1:0]  last_grant;
  int          esv_cnt;

  always @(negedge clk) begin
    if (grant != 2'b00) last_grant <= grant;
    if (eng_size_valid) esv_cnt <= esv_cnt + 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("grant", 32'(grant), 32'(e_grant));
      chk("done", 32'(done), 32'(e_done));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("eng_size_valid", 32'(eng_size_valid),
          32'(e_esv));
      chk("eng_data_start", 32'(eng_data_start),
          32'(e_start));
      chk("result", result, e_result);
      if (c_size) chk("eng_size", 32'(eng_size),
                      32'(e_size));
      if (c_data) chk("eng_data", 32'(eng_data),
                      32'(e_data));
      if (c_err) chk("err", 32'(err), 32'(e_err));
    end
  end

  function automatic logic [31:0] adler(input int n);
    int unsigned a = 1;
    int unsigned b = 0;
    for (int i = 0; i < n; i++) begin
      a = (a + 32'(bytes_m[i])) % 65521;
      b = (b + a) % 65521;
    end
    return {b[15:0], a[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic defaults();
    e_grant  = 2'b00;
    e_done   = 2'b00;
    e_busy   = 1'b1;
    e_esv    = 1'b0;
    e_start  = 1'b0;
    e_err    = 1'b0;
    c_size   = 1'b0;
    c_data   = 1'b0;
    c_err    = 1'b0;
    e_result = res_m;
    eng_checksum_valid = 1'b0;
    eng_checksum = $urandom;
    data0 = 8'($urandom);
    data1 = 8'($urandom);
  endtask

  task automatic idle_exp();
    defaults();
    e_busy = 1'b0;
    req    = 2'b00;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      idle_exp();
      tick();
    end
    idle_exp();
  endtask

  task automatic reset_now();
    chk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_esv", 32'(eng_size_valid), 0);
    chk("rst_start", 32'(eng_data_start), 0);
    chk("rst_result", result, 0);
    chk("rst_eng_size", 32'(eng_size), 0);
    chk("rst_err", 32'(err), 0);
    prio_m = 0;
    res_m  = 32'h0;
    req    = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
    idle_exp();
    chk_en = 1'b1;
  endtask

  // One whole transfer starting in an IDLE cycle.
  // resp: WAIT cycle of engine valid (0 = silent).
  // spur: cycle index of a spurious valid (-1 none).
  // rst_at: cycle index of async reset (-1 none).
  task automatic xfer(input logic [1:0] rq,
                      input int s0, input int s1,
                      input int resp, input int spur,
                      input bit drop, input int rst_at,
                      input bit abc);
    int w, n;
    bit ok;
    logic [31:0] ck;
    w = (rq == 2'b11) ? prio_m : (rq[1] ? 1 : 0);
    n = (w == 1) ? s1 : s0;
    if (n == 0 && spur > 0) spur = -1;
    if (spur > n + 1) spur = -1;
    for (int i = 0; i < n; i++)
      bytes_m[i] = 8'($urandom);
    if (abc) begin
      bytes_m[0] = 8'h61;
      bytes_m[1] = 8'h62;
      bytes_m[2] = 8'h63;
    end
    ck = adler(n);
    ok = (resp >= 1 && resp <= TO);
    // IDLE: arbitration
    defaults();
    e_busy = 1'b0;
    req    = rq;
    size0  = 22'(s0);
    size1  = 22'(s1);
    if (spur == 0) eng_checksum_valid = 1'b1;
    tick();
    if (n == 0) begin
      defaults();
      res_m       = ADLER_EMPTY;
      e_result    = res_m;
      e_done[w]   = 1'b1;
      c_err       = 1'b1;
      e_err       = 1'b0;
      prio_m      = 1 - w;
      tick();
      idle_exp();
      return;
    end
    // SIZE
    defaults();
    e_grant[w] = 1'b1;
    e_esv      = 1'b1;
    c_size     = 1'b1;
    e_size     = 22'(n);
    if (spur == 1) eng_checksum_valid = 1'b1;
    tick();
    if (drop) req = 2'b00;
    // STREAM
    for (int k = 0; k < n; k++) begin
      defaults();
      if (w == 1) data1 = bytes_m[k];
      else data0 = bytes_m[k];
      c_data  = 1'b1;
      e_data  = bytes_m[k];
      e_start = (k == 0);
      if (spur == k + 2) eng_checksum_valid = 1'b1;
      if (rst_at == k + 2) begin
        reset_now();
        return;
      end
      tick();
    end
    // WAIT
    for (int j = 1; j <= TO; j++) begin
      defaults();
      if (j == resp) begin
        eng_checksum_valid = 1'b1;
        eng_checksum       = ck;
      end
      tick();
      if (j == resp) break;
    end
    // DONE
    defaults();
    res_m     = ok ? ck : 32'h0;
    e_result  = res_m;
    e_done[w] = 1'b1;
    c_err     = 1'b1;
    e_err     = !ok;
    prio_m    = 1 - w;
    tick();
    idle_exp();
  endtask

  initial begin
    rst_n  = 1'b0;
    req    = 2'b00;
    size0  = '0;
    size1  = '0;
    data0  = '0;
    data1  = '0;
    eng_checksum_valid = 1'b0;
    eng_checksum = '0;
    prio_m = 0;
    res_m  = 32'h0;
    last_grant = 2'b00;
    esv_cnt = 0;
    #3;
    chk("init_busy", 32'(busy), 0);
    chk("init_grant", 32'(grant), 0);
    chk("init_done", 32'(done), 0);
    chk("init_result", result, 0);
    chk("init_eng_size", 32'(eng_size), 0);
    chk("init_err", 32'(err), 0);
    chk("init_esv", 32'(eng_size_valid), 0);
    chk("init_start", 32'(eng_data_start), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_exp();
    chk_en = 1'b1;

    bytes_m[0] = 8'h61;
    bytes_m[1] = 8'h62;
    bytes_m[2] = 8'h63;
    chk("model_abc", adler(3), 32'h024D0127);

    // both requesting from reset: 0 then 1
    last_grant = 2'b00;
    xfer(2'b11, 1, 1, 2, -1, 0, -1, 0);
    chk("rr_first", 32'(last_grant), 32'h1);
    xfer(2'b11, 1, 1, 2, -1, 0, -1, 0);
    chk("rr_second", 32'(last_grant), 32'h2);
    idle(1);

    // "abc" on requester 0
    xfer(2'b01, 3, 0, 2, -1, 0, -1, 1);
    chk("abc_result", result, 32'h024D0127);
    idle(1);

    // empty message: no grant, no size strobe
    last_grant = 2'b00;
    esv_cnt = 0;
    xfer(2'b01, 0, 7, 1, -1, 0, -1, 0);
    chk("empty_result", result, 32'h1);
    chk("empty_grant", 32'(last_grant), 0);
    chk("empty_esv", 32'(esv_cnt), 0);
    idle(1);

    // silent engine on requester 1
    xfer(2'b10, 4, 2, 0, -1, 0, -1, 0);
    chk("timeout_result", result, 32'h0);
    idle(1);

    // valid on the expiry cycle
    xfer(2'b10, 0, 3, TO, -1, 0, -1, 0);
    idle(1);

    // reset during STREAM, then a clean transfer
    xfer(2'b01, 5, 0, 3, -1, 0, 4, 0);
    xfer(2'b01, 4, 0, 3, -1, 0, -1, 0);
    idle(1);

    // spurious valid in STREAM, req dropped early
    xfer(2'b01, 4, 0, 3, 3, 1, -1, 0);
    idle(1);

    for (int it = 0; it < 60; it++) begin
      xfer(2'($urandom_range(1, 3)),
           $urandom_range(0, 6),
           $urandom_range(0, 6),
           $urandom_range(0, TO),
           $urandom_range(0, 9) - 1,
           1'($urandom_range(0, 1)),
           -1, 0);
      idle($urandom_range(0, 2));
    end

    idle(2);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
